uart_tx_feeder: RTL and testbench

- Buffers 16-bit words produced by the I2C capture logic and launches them one at a time into the UART transmitter.
- Sits directly upstream of the transmitter and drives its word and enable inputs.
- Paces launches on the transmitter's busy and done outputs so that no word is dropped or sent twice.
- Absorbs bursts from the bus side in a circular FIFO and flags overflow.

---
 rtl/uart_tx_feeder.sv | 136 +++++++++++++
 tb/tb_uart_tx_feeder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Word FIFO in front of the UART transmitter. Words are launched one at a time,
// paced on the transmitter's busy/done handshake with a guard gap after each frame.
module uart_tx_feeder #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_Wr_Data,
  input  logic                  i_Wr_Valid,
  output logic                  o_Wr_Full,
  output logic                  o_Overflow,
  input  logic                  i_Overflow_Clr,
  output logic [ADDR_WIDTH:0]   o_Fifo_Count,
  output logic [DATA_WIDTH-1:0] o_Tx_Byte,
  output logic                  o_Tx_Enable,
  input  logic                  i_Tx_Busy,
  input  logic                  i_Tx_Done,
  output logic                  o_Idle
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int GW    = $clog2(GUARD_CYCLES + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [GW-1:0]       GUARD_LOAD = GW'(GUARD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GUARD
  } state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_WIDTH:0]     count_reg, count_next;
  logic [GW-1:0]           guard_reg, guard_next;
  logic                    done_seen_reg, done_seen_next;
  logic                    full_reg, overflow_reg, tx_en_reg, idle_reg;
  logic [DATA_WIDTH-1:0]   tx_byte_reg;
  logic                    launch, pop, push, overflow_event;

  always_comb begin
    state_next     = state_reg;
    guard_next     = guard_reg;
    done_seen_next = done_seen_reg;
    launch         = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (count_reg != '0 && !i_Tx_Busy) begin
          launch     = 1'b1;
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        // A done arriving before busy still closes the frame.
        if (i_Tx_Busy || i_Tx_Done) begin
          done_seen_next = i_Tx_Done;
          state_next     = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (i_Tx_Done || done_seen_reg) begin
          guard_next     = GUARD_LOAD;
          done_seen_next = 1'b0;
          state_next     = S_GUARD;
        end
      end
      S_GUARD: begin
        if (guard_reg == '0) state_next = S_IDLE;
        else                 guard_next = guard_reg - GW'(1);
      end
      default: state_next = S_IDLE;
    endcase
  end

  // A pop in the launch cycle frees a slot, so a write while full still lands.
  assign pop            = (state_reg == S_LAUNCH);
  assign push           = i_Wr_Valid && (!full_reg || pop);
  assign overflow_event = i_Wr_Valid && full_reg && !pop;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (ADDR_WIDTH + 1)'(1);
      2'b01:   count_next = count_reg - (ADDR_WIDTH + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= S_IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      guard_reg     <= '0;
      done_seen_reg <= 1'b0;
      full_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      tx_en_reg     <= 1'b0;
      tx_byte_reg   <= '0;
      idle_reg      <= 1'b1;
    end else begin
      state_reg     <= state_next;
      guard_reg     <= guard_next;
      done_seen_reg <= done_seen_next;
      count_reg     <= count_next;
      full_reg      <= (count_next == DEPTH_CNT);
      if (push) wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + ADDR_WIDTH'(1);
      if (i_Overflow_Clr)      overflow_reg <= 1'b0;
      else if (overflow_event) overflow_reg <= 1'b1;
      tx_en_reg <= launch;
      if (launch) tx_byte_reg <= mem[rd_ptr_reg];
      idle_reg <= (count_next == '0) && (state_next == S_IDLE);
    end
  end

  // Storage kept free of reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_reg] <= i_Wr_Data;
  end

  assign o_Wr_Full    = full_reg;
  assign o_Overflow   = overflow_reg;
  assign o_Fifo_Count = count_reg;
  assign o_Tx_Byte    = tx_byte_reg;
  assign o_Tx_Enable  = tx_en_reg;
  assign o_Idle       = idle_reg;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a simple transmitter model
// (10-cycle busy frame followed by a 2-cycle done).
module tb_uart_tx_feeder;

  localparam int FRAME_LEN = 10;
  localparam int DONE_LEN  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_full;
  logic        ovf;
  logic        ovf_clr;
  logic [4:0]  fifo_count;
  logic [15:0] tx_byte;
  logic        tx_en;
  logic        tx_busy;
  logic        tx_done;
  logic        idle;

  logic        stall;
  logic        in_frame;
  logic        done_m;
  int          fcnt, dcnt, done_cyc, cyc;
  bit          done_valid;
  logic [15:0] lw [$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign tx_busy = stall || in_frame;
  assign tx_done = done_m;

  uart_tx_feeder #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .GUARD_CYCLES(2)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_Wr_Data      (wr_data),
    .i_Wr_Valid     (wr_valid),
    .o_Wr_Full      (wr_full),
    .o_Overflow     (ovf),
    .i_Overflow_Clr (ovf_clr),
    .o_Fifo_Count   (fifo_count),
    .o_Tx_Byte      (tx_byte),
    .o_Tx_Enable    (tx_en),
    .i_Tx_Busy      (tx_busy),
    .i_Tx_Done      (tx_done),
    .o_Idle         (idle)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    lw.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic write_word(input logic [15:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    tick(1);
    wr_valid = 1'b0;
  endtask

  // Transmitter model: busy for FRAME_LEN cycles after a launch, then done for DONE_LEN.
  initial begin
    in_frame   = 1'b0;
    done_m     = 1'b0;
    fcnt       = 0;
    dcnt       = 0;
    done_cyc   = 0;
    done_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame   = 1'b0;
        done_m     = 1'b0;
        done_valid = 1'b0;
      end else if (tx_en) begin
        $display("launch word=%04h cycle=%0d", tx_byte, cyc);
        check("en_while_busy", {31'b0, in_frame | done_m | stall}, 32'd0);
        if (done_valid) check("launch_gap", cyc - done_cyc, 32'd4);
        lw.push_back(tx_byte);
        in_frame = 1'b1;
        fcnt     = FRAME_LEN;
      end else if (in_frame) begin
        fcnt--;
        if (fcnt == 0) begin
          in_frame   = 1'b0;
          done_m     = 1'b1;
          dcnt       = DONE_LEN;
          done_cyc   = cyc;
          done_valid = 1'b1;
        end
      end else if (done_m) begin
        dcnt--;
        if (dcnt == 0) done_m = 1'b0;
      end
    end
  end

  initial begin
    cyc      = 0;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    ovf_clr  = 1'b0;
    stall    = 1'b0;
    tick(3);
    check("rst_idle", idle, 1);
    check("rst_count", fifo_count, 0);
    check("rst_full", wr_full, 0);
    check("rst_ovf", ovf, 0);
    check("rst_en", tx_en, 0);
    check("rst_byte", tx_byte, 0);
    rst_n = 1'b1;
    tick(1);

    // Single word: enable exactly 2 cycles after the write strobe.
    write_word(16'hA55A);
    check("t1_en_early", tx_en, 0);
    tick(1);
    check("t1_en", tx_en, 1);
    check("t1_byte", tx_byte, 16'hA55A);
    tick(1);
    check("t1_en_pulse", tx_en, 0);
    tick(11);
    check("t1_idle_in_guard", idle, 0);
    tick(1);
    check("t1_idle_after", idle, 1);
    tick(20);
    check("t1_launches", lw.size(), 1);
    check("t1_byte_hold", tx_byte, 16'hA55A);

    // Burst of 16 into a stalled transmitter, then write in the launch cycle.
    do_reset();
    stall = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) check("t2_not_full_15", wr_full, 0);
      write_word(16'(i));
    end
    check("t2_full", wr_full, 1);
    check("t2_count", fifo_count, 16);
    stall = 1'b0;
    tick(1);
    check("t2_first_en", tx_en, 1);
    check("t2_first_byte", tx_byte, 16'h0001);
    write_word(16'h0011);
    check("t2_simul_count", fifo_count, 16);
    check("t2_simul_full", wr_full, 1);
    check("t2_simul_ovf", ovf, 0);
    tick(17 * 14 + 20);
    check("t2_launches", lw.size(), 17);
    for (int i = 0; i < 17 && i < lw.size(); i++) check("t2_order", lw[i], 32'(i + 1));
    check("t2_idle_end", idle, 1);

    // Overflow: 17th write dropped; clear wins over a simultaneous overflow.
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) check("t3_ovf_before", ovf, 0);
      write_word(16'h0100 + 16'(i));
    end
    check("t3_ovf_set", ovf, 1);
    check("t3_count", fifo_count, 16);
    tick(2);
    check("t3_ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    write_word(16'h0999);
    ovf_clr = 1'b0;
    check("t3_ovf_clr_prio", ovf, 0);
    check("t3_count_after_clr", fifo_count, 16);
    stall = 1'b0;
    tick(16 * 14 + 20);
    check("t3_launches", lw.size(), 16);
    for (int i = 0; i < 16 && i < lw.size(); i++) check("t3_order", lw[i], 32'h0100 + 32'(i));

    // Two queued words with a 2-cycle done: second launch once, after the guard.
    do_reset();
    stall = 1'b1;
    write_word(16'hBEEF);
    write_word(16'h1234);
    stall = 1'b0;
    tick(40);
    check("t5_launches", lw.size(), 2);
    if (lw.size() == 2) begin
      check("t5_word0", lw[0], 16'hBEEF);
      check("t5_word1", lw[1], 16'h1234);
    end
    check("t5_idle", idle, 1);

    // Asynchronous reset in the middle of a frame.
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 6; i++) write_word(16'h0200 + 16'(i));
    stall = 1'b0;
    tick(1);
    check("t6_en", tx_en, 1);
    tick(5);
    check("t6_count_pre", fifo_count, 5);
    rst_n = 1'b0;
    #1;
    check("t6_en_rst", tx_en, 0);
    check("t6_count_rst", fifo_count, 0);
    check("t6_idle_rst", idle, 1);
    check("t6_byte_rst", tx_byte, 0);
    lw.delete();
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check("t6_no_launch", lw.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
